// File: rtl/run_sequencer_if.sv
// run_sequencer_if
//   Groups the run handshake and the instruction-side signals of the
//   run sequencer.
//   Ports (signals):
//     req           host -> sequencer   run request, level-sampled
//     ack           sequencer -> host   run complete, level
//     timeout       sequencer -> host   last run ended by the watchdog
//     halt          decoder -> sequencer  instruction at pc is halt
//     branch_taken  decoder -> sequencer  branch at pc is taken
//     branch_target LUT -> sequencer    absolute branch target
//     pc            sequencer -> ROM    address executing this cycle
//     run           sequencer -> core   write enable for regfile/dmem
//   Handshake: the host raises req; one start happens per rising period of
//   req (req must be seen low between runs). ack stays high from the end
//   of a run until the next start edge and drops the cycle after it.
interface run_sequencer_if #(
  parameter int PW = 10
);
  logic          req;
  logic          ack;
  logic          timeout;
  logic          halt;
  logic          branch_taken;
  logic [PW-1:0] branch_target;
  logic [PW-1:0] pc;
  logic          run;

  // Host/core side.
  modport master (
    output req, halt, branch_taken, branch_target,
    input  ack, timeout, pc, run
  );

  // Sequencer side.
  modport slave (
    input  req, halt, branch_taken, branch_target,
    output ack, timeout, pc, run
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer
//   Owns the program counter. Starts execution on a host request, steps
//   or branches the pc each RUN cycle, and stops on a halt instruction or
//   on watchdog expiry, then holds ack until the next request.
//   Ports:
//     clk        single clock, rising edge
//     reset      asynchronous, active-high
//     bus        run_sequencer_if.slave (req/ack/timeout/halt/branch/pc/run)
//     dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module run_sequencer #(
  parameter int PW         = 10,
  parameter int START_ADDR = 0,
  parameter int WD_LIMIT   = 1023
) (
  input  logic            clk,
  input  logic            reset,
  run_sequencer_if.slave  bus,
  output logic [1:0]      dbg_state
);

  localparam int WDW = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
  // Count value during the last permitted RUN cycle.
  localparam logic [WDW-1:0] WD_LAST = WDW'((WD_LIMIT == 0) ? 0 : WD_LIMIT - 1);
  localparam logic [PW-1:0]  PC_RST  = PW'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pc_q, pc_d;
  logic           ack_q, ack_d;
  logic           to_q, to_d;
  logic           armed_q, armed_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           wd_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      armed_q <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      armed_q <= armed_d;
      wd_q    <= wd_d;
    end
  end

  assign wd_hit = (WD_LIMIT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ack_d   = ack_q;
    to_d    = to_q;
    wd_d    = wd_q;
    // Any edge with req low re-arms, so a held req yields one run only.
    armed_d = bus.req ? armed_q : 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (bus.req && armed_q) begin
          state_d = RUN;
          ack_d   = 1'b0;
          to_d    = 1'b0;
          wd_d    = '0;
          armed_d = 1'b0;
        end
      end
      RUN: begin
        // Halt outranks a simultaneous taken branch.
        if (!bus.halt && bus.branch_taken) pc_d = bus.branch_target;
        else                               pc_d = pc_q + PW'(1);

        if (bus.halt) begin
          state_d = DONE;
          ack_d   = 1'b1;
          to_d    = 1'b0;
        end else if (wd_hit) begin
          state_d = DONE;
          ack_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.ack     = ack_q;
  assign bus.timeout = to_q;
  // The halt instruction itself performs no writes.
  assign bus.run     = (state_q == RUN) && !bus.halt;
  assign dbg_state   = state_q;

endmodule
